// File: rtl/dual_fetch_queue_if.sv
// Fetch-queue bus: imem ports on one side, issue window on the other.
// master = fetch queue, slave = imem / issue environment.
interface dual_fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 12,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] address_imem_1;
    logic [DW-1:0] q_imem_1;
    logic [AW-1:0] address_imem_2;
    logic [DW-1:0] q_imem_2;
    logic [1:0]    deq_count;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [DW-1:0] inst_0;
    logic [AW-1:0] pc_0;
    logic          valid_0;
    logic [DW-1:0] inst_1;
    logic [AW-1:0] pc_1;
    logic          valid_1;
    logic [CW-1:0] count;

    modport master (
        output address_imem_1, address_imem_2,
        output inst_0, pc_0, valid_0,
        output inst_1, pc_1, valid_1, count,
        input  q_imem_1, q_imem_2,
        input  deq_count, redirect, redirect_pc
    );

    modport slave (
        input  address_imem_1, address_imem_2,
        input  inst_0, pc_0, valid_0,
        input  inst_1, pc_1, valid_1, count,
        output q_imem_1, q_imem_2,
        output deq_count, redirect, redirect_pc
    );
endinterface

// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch stage: owns the PC, fetches PC/PC+1 each cycle into
// a circular queue and presents the two oldest entries to issue.
// Ports: clock, reset (async, active-high), bus (dual_fetch_queue_if.master).
module dual_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 12,
    parameter int DW    = 32
) (
    input  logic              clock,
    input  logic              reset,
    dual_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [DW-1:0] inst_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic [1:0]    enq;
    logic [1:0]    deq_req;
    logic [1:0]    eff;
    logic [PW-1:0] tail_plus;
    logic [PW-1:0] head_plus;
    logic [AW-1:0] pc_plus;

    assign tail_plus = tail + 1'b1;
    assign head_plus = head + 1'b1;
    assign pc_plus   = pc + 1'b1;

    // Enqueue depends only on registered occupancy; slots freed by a
    // same-cycle dequeue become usable next cycle.
    always_comb begin
        enq = 2'd0;
        if (count <= CW'(DEPTH - 2))
            enq = 2'd2;
        else if (count == CW'(DEPTH - 1))
            enq = 2'd1;
    end

    // Request of 3 behaves as 2; never pop more than is held.
    always_comb begin
        deq_req = bus.deq_count[1] ? 2'd2 : {1'b0, bus.deq_count[0]};
        eff     = deq_req;
        if (CW'(deq_req) > count)
            eff = count[1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.redirect) begin
            pc    <= bus.redirect_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            pc    <= pc + AW'(enq);
            head  <= head + PW'(eff);
            tail  <= tail + PW'(enq);
            count <= count + CW'(enq) - CW'(eff);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (!bus.redirect && enq != 2'd0) begin
            inst_mem[tail] <= bus.q_imem_1;
            pc_mem[tail]   <= pc;
        end
        if (!bus.redirect && enq == 2'd2) begin
            inst_mem[tail_plus] <= bus.q_imem_2;
            pc_mem[tail_plus]   <= pc_plus;
        end
    end

    assign bus.address_imem_1 = pc;
    assign bus.address_imem_2 = pc_plus;

    assign bus.inst_0  = inst_mem[head];
    assign bus.pc_0    = pc_mem[head];
    assign bus.valid_0 = (count != '0);
    assign bus.inst_1  = inst_mem[head_plus];
    assign bus.pc_1    = pc_mem[head_plus];
    assign bus.valid_1 = (count >= CW'(2));
    assign bus.count   = count;
endmodule

// File: doc/dual_fetch_queue.md
Name: dual_fetch_queue

Overview:
- Front-end fetch stage of the dual-issue pipeline; sits directly upstream of decode/issue.
- Owns the PC and drives both instruction-memory ports every cycle: port 1 gets PC, port 2 gets PC+1.
- Buffers returned instructions in a circular queue and presents the two oldest entries to issue.
- Issue consumes 0, 1 or 2 entries per cycle; a redirect from branch resolution flushes the queue and reloads the PC.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- AW, 12, instruction address width; PC wraps modulo 2^AW.
- DW, 32, instruction width.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address_imem_1  out  AW  imem port 1 address; equals PC.
- q_imem_1  in  DW  imem port 1 data; valid before the next rising edge.
- address_imem_2  out  AW  imem port 2 address; equals (PC+1) mod 2^AW.
- q_imem_2  in  DW  imem port 2 data; valid before the next rising edge.
- deq_count  in  2  entries consumed by issue this cycle (0, 1 or 2; value 3 is treated as 2).
- redirect  in  1  flush the queue and load redirect_pc.
- redirect_pc  in  AW  new PC on redirect.
- inst_0  out  DW  oldest queued instruction.
- pc_0  out  AW  PC of inst_0.
- valid_0  out  1  inst_0 is valid (count >= 1).
- inst_1  out  DW  second-oldest queued instruction.
- pc_1  out  AW  PC of inst_1.
- valid_1  out  1  inst_1 is valid (count >= 2).
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - PC=0, head=0, tail=0, count=0.
  - valid_0=valid_1=0, so address_imem_1=0 and address_imem_2=1.
  - inst/pc outputs are don't-care while their valid is 0.
  - Storage array is not cleared.
- imem timing:
  - imem is clocked on the inverted clock, so data for the addresses driven in cycle N is sampled at the rising edge ending cycle N.
  - An instruction fetched in cycle N appears at inst_0/inst_1 in cycle N+1 at the earliest.
- Enqueue decision uses the registered count at the start of the cycle; same-cycle dequeue does not free slots. Let free = DEPTH - count.
  - free >= 2: write q_imem_1 at tail and q_imem_2 at tail+1, each with its PC; tail += 2; PC += 2.
  - free == 1: write q_imem_1 only; tail += 1; PC += 1.
  - free == 0: no write; PC holds and the addresses hold.
- Dequeue:
  - eff = min(deq_count clamped to 2, count); head += eff.
  - Dequeue never underflows; a request exceeding occupancy is silently clamped.
- Occupancy update: next count = count + enq - eff, computed in a single update. Simultaneous enqueue and dequeue is legal in every state, including full and empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The tail+1 write wraps independently of tail.
- Redirect:
  - Has priority over enqueue and dequeue.
  - At the edge: count=0, head=tail=0, PC=redirect_pc, and no enqueue occurs. The instructions fetched in the redirect cycle are discarded.
  - The next cycle drives redirect_pc and redirect_pc+1; those instructions are visible the cycle after.
  - Redirect penalty is 2 cycles from assertion to valid_0.
- PC arithmetic is modulo 2^AW: PC=2^AW-1 fetches 0xFFF and 0x000 in the same cycle, and the next PC is 0x001.
- Outputs:
  - inst_0, pc_0 = entry[head]; inst_1, pc_1 = entry[head+1 mod DEPTH].
  - Outputs are combinational from registered state only; there is no combinational path from deq_count or redirect to any output.

Test Plan:
1. Reset, then deq_count=0 for 6 cycles -> addresses 0/1, 2/3, 4/5, 6/7. count reaches 8 after 4 cycles, then the addresses hold at 8/9. pc_0=0, pc_1=1, valid_0=valid_1=1.
2. Reset, then deq_count=2 every cycle with imem returning address+0x1000 -> from cycle 2 onward, each cycle presents a consecutive pair (0x1000/0x1001, 0x1002/0x1003, ...). count stays at 2 and no pair is skipped.
3. Fill to 8, then apply deq_count=1 for one cycle -> count=7, no enqueue that cycle. Next cycle (deq=0): a single enqueue of address 8, PC=9, count=8.
4. With count=6, assert redirect with redirect_pc=0x100 and deq_count=2 -> next cycle count=0, valid_0=0, addresses 0x100/0x101. The following cycle pc_0=0x100, pc_1=0x101.
5. Redirect to 0xFFF -> addresses 0xFFF/0x000. Next cycle pc_0=0xFFF, pc_1=0x000, address_imem_1=0x001. Pointer wrap is exercised by running the queue 3×DEPTH entries with alternating deq 1/2 and checking that the PC sequence stays monotonic.
6. With count=1, apply deq_count=3 -> clamped to 1 with no underflow, count=2 (the same-cycle enqueue of 2). Asserting reset mid-fill drops valid_0 before the next clock edge.
